// File: rtl/bmp_stream_parser.sv
// Streaming 24-bit BMP parser: validates the fixed-size header, then emits bottom-up stored
// pixels as top-down (row, col) coordinates with a ready/valid pixel handshake.
module bmp_stream_parser #(
  parameter int unsigned HDR_BYTES = 54,
  parameter int unsigned MAX_DIM   = 2048
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  DATA_R,
  output logic [7:0]  DATA_G,
  output logic [7:0]  DATA_B,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [10:0] row,
  output logic [10:0] col,
  output logic [31:0] out_width,
  output logic [31:0] out_height,
  output logic        hdr_done,
  output logic        frame_done,
  output logic        error
);

  typedef enum logic [1:0] {StHeader, StPixel, StPad, StErr} state_e;

  state_e      state_q, state_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] sig_q, sig_d, bpp_q, bpp_d;
  logic [31:0] off_q, off_d, wcap_q, wcap_d, hcap_q, hcap_d;
  logic [31:0] out_w_q, out_w_d, out_h_q, out_h_d;
  logic [10:0] line_q, line_d, col_cnt_q, col_cnt_d;
  logic [10:0] row_o_q, row_o_d, col_o_q, col_o_d;
  logic [1:0]  phase_q, phase_d, pad_cnt_q, pad_cnt_d;
  logic [7:0]  b_q, b_d, g_q, g_d;
  logic [7:0]  data_r_q, data_r_d, data_g_q, data_g_d, data_b_q, data_b_d;
  logic        pix_valid_q, pix_valid_d, hdr_done_q, hdr_done_d;
  logic        frame_done_q, frame_done_d, error_q, error_d, end_pend_q, end_pend_d;
  logic        accept, hdr_ok, line_end, finish;

  always_comb begin
    in_ready = 1'b0;
    if (!RESET) begin
      unique case (state_q)
        StHeader: in_ready = 1'b1;
        StPixel:  in_ready = !(pix_valid_q && !pix_ready) && !end_pend_q;
        StPad:    in_ready = !end_pend_q;
        StErr:    in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    sig_d        = sig_q;
    bpp_d        = bpp_q;
    off_d        = off_q;
    wcap_d       = wcap_q;
    hcap_d       = hcap_q;
    out_w_d      = out_w_q;
    out_h_d      = out_h_q;
    line_d       = line_q;
    col_cnt_d    = col_cnt_q;
    row_o_d      = row_o_q;
    col_o_d      = col_o_q;
    phase_d      = phase_q;
    pad_cnt_d    = pad_cnt_q;
    b_d          = b_q;
    g_d          = g_q;
    data_r_d     = data_r_q;
    data_g_d     = data_g_q;
    data_b_d     = data_b_q;
    pix_valid_d  = pix_valid_q;
    hdr_done_d   = hdr_done_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    end_pend_d   = end_pend_q;
    hdr_ok       = 1'b0;
    line_end     = 1'b0;
    finish       = 1'b0;

    if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;

    unique case (state_q)
      StHeader: begin
        if (accept) begin
          case (byte_cnt_q)
            6'd0:  sig_d[7:0]    = in_byte;
            6'd1:  sig_d[15:8]   = in_byte;
            6'd10: off_d[7:0]    = in_byte;
            6'd11: off_d[15:8]   = in_byte;
            6'd12: off_d[23:16]  = in_byte;
            6'd13: off_d[31:24]  = in_byte;
            6'd18: wcap_d[7:0]   = in_byte;
            6'd19: wcap_d[15:8]  = in_byte;
            6'd20: wcap_d[23:16] = in_byte;
            6'd21: wcap_d[31:24] = in_byte;
            6'd22: hcap_d[7:0]   = in_byte;
            6'd23: hcap_d[15:8]  = in_byte;
            6'd24: hcap_d[23:16] = in_byte;
            6'd25: hcap_d[31:24] = in_byte;
            6'd28: bpp_d[7:0]    = in_byte;
            6'd29: bpp_d[15:8]   = in_byte;
            default: ;
          endcase
          // Unsigned bounds also reject negative (bit 31 set) heights.
          hdr_ok = (sig_d == 16'h4D42) && (off_d == 32'(HDR_BYTES)) && (bpp_d == 16'd24) &&
                   (wcap_d != 32'd0) && (wcap_d <= 32'(MAX_DIM)) &&
                   (hcap_d != 32'd0) && (hcap_d <= 32'(MAX_DIM));
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (byte_cnt_q == 6'(HDR_BYTES - 1)) begin
            byte_cnt_d = 6'd0;
            if (hdr_ok) begin
              state_d    = StPixel;
              hdr_done_d = 1'b1;
              out_w_d    = wcap_d;
              out_h_d    = hcap_d;
              line_d     = 11'd0;
              col_cnt_d  = 11'd0;
              phase_d    = 2'd0;
            end else begin
              state_d = StErr;
              error_d = 1'b1;
            end
          end
        end
      end
      StPixel: begin
        if (accept) begin
          unique case (phase_q)
            2'd0: begin
              b_d     = in_byte;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = in_byte;
              phase_d = 2'd2;
            end
            default: begin
              data_r_d    = in_byte;
              data_g_d    = g_q;
              data_b_d    = b_q;
              row_o_d     = out_h_q[10:0] - 11'd1 - line_q;
              col_o_d     = col_cnt_q;
              pix_valid_d = 1'b1;
              phase_d     = 2'd0;
              if (col_cnt_q == out_w_q[10:0] - 11'd1) begin
                col_cnt_d = 11'd0;
                // Row padding reduces to width mod 4 for 3-byte pixels.
                if (out_w_q[1:0] != 2'd0) begin
                  state_d   = StPad;
                  pad_cnt_d = out_w_q[1:0];
                end else begin
                  line_end = 1'b1;
                end
              end else begin
                col_cnt_d = col_cnt_q + 11'd1;
              end
            end
          endcase
        end
      end
      StPad: begin
        if (accept) begin
          pad_cnt_d = pad_cnt_q - 2'd1;
          if (pad_cnt_q == 2'd1) line_end = 1'b1;
        end
      end
      StErr: ;
    endcase

    if (line_end) begin
      if (line_q == out_h_q[10:0] - 11'd1) begin
        if (pix_valid_d) end_pend_d = 1'b1;
        else             finish     = 1'b1;
      end else begin
        line_d  = line_q + 11'd1;
        state_d = StPixel;
      end
    end

    // Frame end waits for the last pixel to leave; inputs are stalled meanwhile.
    if (end_pend_q && (!pix_valid_q || pix_ready)) finish = 1'b1;

    if (finish) begin
      state_d      = StHeader;
      hdr_done_d   = 1'b0;
      frame_done_d = 1'b1;
      end_pend_d   = 1'b0;
      line_d       = 11'd0;
      col_cnt_d    = 11'd0;
      phase_d      = 2'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StHeader;
      byte_cnt_q   <= '0;
      sig_q        <= '0;
      bpp_q        <= '0;
      off_q        <= '0;
      wcap_q       <= '0;
      hcap_q       <= '0;
      out_w_q      <= '0;
      out_h_q      <= '0;
      line_q       <= '0;
      col_cnt_q    <= '0;
      row_o_q      <= '0;
      col_o_q      <= '0;
      phase_q      <= '0;
      pad_cnt_q    <= '0;
      b_q          <= '0;
      g_q          <= '0;
      data_r_q     <= '0;
      data_g_q     <= '0;
      data_b_q     <= '0;
      pix_valid_q  <= 1'b0;
      hdr_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
      end_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      sig_q        <= sig_d;
      bpp_q        <= bpp_d;
      off_q        <= off_d;
      wcap_q       <= wcap_d;
      hcap_q       <= hcap_d;
      out_w_q      <= out_w_d;
      out_h_q      <= out_h_d;
      line_q       <= line_d;
      col_cnt_q    <= col_cnt_d;
      row_o_q      <= row_o_d;
      col_o_q      <= col_o_d;
      phase_q      <= phase_d;
      pad_cnt_q    <= pad_cnt_d;
      b_q          <= b_d;
      g_q          <= g_d;
      data_r_q     <= data_r_d;
      data_g_q     <= data_g_d;
      data_b_q     <= data_b_d;
      pix_valid_q  <= pix_valid_d;
      hdr_done_q   <= hdr_done_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
      end_pend_q   <= end_pend_d;
    end
  end

  assign DATA_R     = data_r_q;
  assign DATA_G     = data_g_q;
  assign DATA_B     = data_b_q;
  assign pix_valid  = pix_valid_q;
  assign row        = row_o_q;
  assign col        = col_o_q;
  assign out_width  = out_w_q;
  assign out_height = out_h_q;
  assign hdr_done   = hdr_done_q;
  assign frame_done = frame_done_q;
  assign error      = error_q;

endmodule

// File: doc/bmp_stream_parser.md
BMP_STREAM_PARSER -- requirements
Module: bmp_stream_parser

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 54, header length in bytes (equals the required pixel-data offset).
REQ-002 SHALL have parameter MAX_DIM, default 2048, maximum accepted width and height.
REQ-003 SHALL have ports as follows (clock and reset first):
- CLK  input  1  single clock; all logic on its rising edge.
- RESET  input  1  reset, synchronous, active-high.
- in_byte  input  8  BMP file byte stream, file order.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  parser accepts in_byte this cycle.
- DATA_R, DATA_G, DATA_B  output  8 each  pixel colour.
- pix_valid  output  1  pixel outputs valid.
- pix_ready  input  1  consumer accepts the pixel.
- row, col  output  11 each  pixel coordinates; row 0 = top.
- out_width, out_height  output  32 each  latched header dimensions.
- hdr_done  output  1  header accepted, frame in progress.
- frame_done  output  1  one-cycle pulse at frame end.
- error  output  1  sticky header-error flag.

Function
REQ-004 SHALL transfer a byte only on a rising edge where in_valid && in_ready; a pixel only where pix_valid && pix_ready.
REQ-005 SHALL implement states HEADER, PIXEL, PAD, ERR; reset state HEADER.
REQ-006 HEADER: in_ready=1; count bytes 0..HDR_BYTES-1; capture bytes 0-1 signature, 10-13 offset, 18-21 width, 22-25 height, 28-29 bpp, multi-byte fields little-endian; ignore all other bytes.
REQ-007 On acceptance of header byte HDR_BYTES-1, the header SHALL be valid iff signature=0x42,0x4D; offset=HDR_BYTES; bpp=24; 1<=width<=MAX_DIM; 1<=height<=MAX_DIM, height signed (negative rejected).
REQ-008 Valid header: next cycle state=PIXEL, hdr_done=1, out_width/out_height=captured values, line=0, col=0. Invalid: next cycle state=ERR, error=1.
REQ-009 PIXEL: bytes arrive in B,G,R order; on acceptance of the third (R) byte, load the pixel register and assert pix_valid on the next cycle.
REQ-010 Output row SHALL equal height-1-line (BMP rows are stored bottom-up); col counts 0..width-1 within a line.
REQ-011 In PIXEL, in_ready SHALL equal !(pix_valid && !pix_ready); a pixel register load coinciding with a pixel acceptance keeps pix_valid=1 and loads the new pixel, so sustained throughput is 3 bytes per pixel.
REQ-012 While pix_valid && !pix_ready, DATA_R/G/B, row and col SHALL hold stable.
REQ-013 Row padding: pad = (4 - (3*width mod 4)) mod 4. After the last pixel byte of a line, enter PAD if pad>0 and accept exactly pad bytes (in_ready=1), discarding them; otherwise go directly to the next line or frame end.
REQ-014 Frame end, defined as the last byte of the last line (pixel or pad) being accepted: frame_done SHALL pulse once when the last pixel has also been accepted downstream, then hdr_done=0 and state=HEADER for the next frame. If that pixel is still pending, the pulse SHALL be deferred until its acceptance, and in_ready SHALL stay 0 meanwhile.
REQ-015 ERR: in_ready=0, pix_valid=0, error=1; leave only via RESET.
REQ-016 Widths: byte counter 6 bits, line/col counters 11 bits; pad computed from width[1:0] only.

Reset
REQ-017 RESET high at a rising edge SHALL, on that edge, force state=HEADER, all counters 0, and drive in_ready=0 during reset and 1 in the first cycle after. It SHALL also force pix_valid=0, frame_done=0, hdr_done=0, error=0, DATA_R/G/B=0, row=0, col=0, out_width=0, out_height=0.
REQ-018 RESET mid-frame SHALL discard any partial pixel and the pending pixel; the next accepted byte is header byte 0.

Verification
REQ-019 2x2 frame, 70 bytes (stride 6 plus 2 pad), pix_ready=1: pixels emitted at (1,0),(1,1),(0,0),(0,1) with R/G/B equal to file bytes 2,1,0 of each triplet; one frame_done pulse after byte 69.
REQ-020 Backpressure: pix_ready=0 for 5 cycles with a pixel pending -> pix_valid, data, row and col stable; in_ready=0 in PIXEL; no byte lost when pix_ready returns.
REQ-021 Signature 0x42,0x4E -> error=1 on the cycle after byte 53; in_ready=0; pix_valid never asserts; RESET clears error.
REQ-022 bpp=32 or width=0 or height=0xFFFFFFFE -> error=1, no pixels.
REQ-023 Two back-to-back 4x1 frames (stride 12, no pad) -> 4 pixels each at row 0, cols 0..3; two frame_done pulses; hdr_done falls then re-rises.
REQ-024 RESET asserted after the G byte of a pixel -> all outputs at reset values the next cycle; a fresh 2x2 frame then parses correctly.
